// File: rtl/alsaqr_credit_to_valrdy_fifo_if.sv
// Handshake bundle between a credit-based NoC sender and a valid/ready consumer.
// The slave modport is the bridge's view; the master modport drives both outer sides.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface alsaqr_credit_to_valrdy_fifo_if #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  yummy_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;
    logic [CNT_W-1:0]      occupancy;
    logic                  overflow_err;

    modport slave (
        input  data_in, valid_in, ready_out,
        output yummy_in, data_out, valid_out, occupancy, overflow_err
    );

    modport master (
        output data_in, valid_in, ready_out,
        input  yummy_in, data_out, valid_out, occupancy, overflow_err
    );
endinterface

// File: rtl/alsaqr_credit_to_valrdy_fifo.sv
// Credit (data/valid/yummy) to valid/ready bridge: circular buffer of DEPTH flits,
// one yummy per consumed flit, registered occupancy and sticky overflow flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module alsaqr_credit_to_valrdy_fifo #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    alsaqr_credit_to_valrdy_fifo_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_yummy;
    logic                  r_ovf;

    logic w_full;
    logic w_pop;
    logic w_push;

    // Full/empty is decided from the count alone; a pop frees its slot for a same-cycle push.
    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = (r_count != '0) && bus.ready_out;
    assign w_push = bus.valid_in && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_yummy  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_yummy <= w_pop;
            if (bus.valid_in && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.valid_out    = (r_count != '0);
    assign bus.data_out     = r_mem[r_rd_ptr];
    assign bus.yummy_in     = r_yummy;
    assign bus.occupancy    = r_count;
    assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_alsaqr_credit_to_valrdy_fifo.sv
// Scoreboard bench: the driver queues expected flits as it issues them; a negedge
// monitor runs a cycle model of count/yummy/overflow and checks every output.
module tb_alsaqr_credit_to_valrdy_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsaqr_credit_to_valrdy_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    alsaqr_credit_to_valrdy_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [DW-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    int  m_count = 0;
    bit  m_yummy = 1'b0;
    bit  m_ovf   = 1'b0;
    bit  drv_acc = 1'b0;
    int  y_tally = 0;
    int  p_tally = 0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endfunction

    // Monitor: outputs are sampled mid-cycle, then the model advances with the inputs
    // that will be seen at the next rising edge.
    always @(negedge clk) begin
        bit m_pop;
        bit m_push;
        if (rst) begin
            m_count = 0;
            m_yummy = 1'b0;
            m_ovf   = 1'b0;
            y_tally = 0;
            p_tally = 0;
        end else begin
            chk("valid_out", int'(bus.valid_out), int'(m_count != 0));
            chk("occupancy", int'(bus.occupancy), m_count);
            chk("yummy_in", int'(bus.yummy_in), int'(m_yummy));
            chk("overflow_err", int'(bus.overflow_err), int'(m_ovf));
            if (m_count != 0) begin
                if (exp_q.size() == 0) begin
                    chk("head_present", 0, 1);
                end else begin
                    chk("data_out", int'(bus.data_out), int'(exp_q[0]));
                end
            end
            if (bus.yummy_in) y_tally++;
            m_pop  = (m_count != 0) && bus.ready_out;
            if (m_pop && exp_q.size() != 0) void'(exp_q.pop_front());
            m_push = bus.valid_in && (m_count != DEPTH || m_pop);
            if (bus.valid_in) chk("accept", int'(m_push), int'(drv_acc));
            if (bus.valid_in && !m_push) m_ovf = 1'b1;
            m_yummy = m_pop;
            if (m_pop) p_tally++;
            m_count = m_count + int'(m_push) - int'(m_pop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit acc);
        bus.valid_in  = v;
        bus.data_in   = d;
        bus.ready_out = r;
        drv_acc       = acc;
        if (v && acc) exp_q.push_back(d);
        step();
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, r, 1'b0);
    endtask

    initial begin
        int sent;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.ready_out = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_out", int'(bus.valid_out), 0);
        chk("rst_occupancy", int'(bus.occupancy), 0);
        chk("rst_yummy_in", int'(bus.yummy_in), 0);
        chk("rst_overflow_err", int'(bus.overflow_err), 0);
        rst = 1'b0;
        step();

        // Single flit with consumer ready: out next cycle, yummy the cycle after.
        drive(1'b1, 8'hA5, 1'b1, 1'b1);
        idle(1'b1, 4);

        // Fill with stall, overflow a dropped flit, then full-with-pop accepted.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
        idle(1'b0, 2);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, 8'h10, 1'b1, 1'b1);
        idle(1'b1, 20);
        chk("drain_empty", exp_q.size(), 0);

        // Backpressure: head must hold for 5 stalled cycles.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b1);
        idle(1'b0, 5);
        idle(1'b1, 6);

        // Randomised streaming of 40 flits; valid only when the model has room.
        sent = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            bit v;
            bit r;
            v = ($urandom_range(0, 1) == 1) && (m_count < DEPTH);
            r = ($urandom_range(0, 3) != 0);
            drive(v, 8'h40 + 8'(sent), r, 1'b1);
            if (v) sent++;
        end
        chk("rand_sent", sent, 40);
        idle(1'b1, 20);
        chk("rand_empty", exp_q.size(), 0);
        chk("yummy_eq_pops", y_tally, p_tally);

        // Async reset with 7 buffered flits and a yummy pending.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        bus.ready_out = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid_out", int'(bus.valid_out), 0);
        chk("async_yummy_in", int'(bus.yummy_in), 0);
        chk("async_occupancy", int'(bus.occupancy), 0);
        chk("async_overflow_err", int'(bus.overflow_err), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        drive(1'b1, 8'h3C, 1'b1, 1'b1);
        idle(1'b1, 4);
        chk("final_empty", exp_q.size(), 0);
        chk("final_yummy_eq_pops", y_tally, p_tally);
        chk("final_pops", p_tally, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alsaqr_credit_to_valrdy_fifo.md
Name: alsaqr_credit_to_valrdy_fifo

Overview:
- Parametrised streaming bridge from the on-chip credit-based NoC interface (data/valid/yummy) to a valid/ready consumer, such as an AXI-side adapter.
- Flits go into a circular buffer of DEPTH entries and are forwarded as soon as they are present; there is no store-then-forward burst.
- One credit (a yummy pulse) returns to the sender for each flit the consumer accepts, so the sender's credit count always equals the free buffer slots.
- Adds occupancy reporting and sticky overflow detection.

Parameters:
DATA_WIDTH, `DATA_WIDTH, flit width in bits
DEPTH, 16, buffer entries; power of two, >= 2; equals the sender's initial credit count
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  flit from credit-based sender
valid_in  input  1  flit on data_in is valid this cycle (sender guarantees it holds a credit)
yummy_in  output  1  credit return to sender, one pulse per freed slot
data_out  output  DATA_WIDTH  head flit to consumer
valid_out  output  1  data_out is valid
ready_out  input  1  consumer accepts data_out this cycle
occupancy  output  CNT_W  number of flits currently buffered
overflow_err  output  1  sticky: a flit arrived with no free slot

Behaviour:
- Reset (async assert, clocked-domain deassert assumed by integration):
  - wr_ptr, rd_ptr and count = 0.
  - yummy_in = 0, overflow_err = 0, occupancy = 0, valid_out = 0.
  - Buffer contents are not reset; data_out is don't-care while valid_out = 0.
- push = valid_in && (count != DEPTH || pop).
  - On push: mem[wr_ptr] <= data_in; wr_ptr increments mod DEPTH.
- pop = valid_out && ready_out.
  - On pop: rd_ptr increments mod DEPTH.
- count next:
  - count + 1 on push only.
  - count - 1 on pop only.
  - Unchanged on both, or on neither.
- Full with simultaneous pop: the push is accepted. The slot freed by this cycle's pop is reusable in the same cycle.
- valid_out = (count != 0), driven from registered state only. data_out = mem[rd_ptr]. No combinational path from valid_in or ready_out to valid_out or data_out.
- Latency: a flit pushed in cycle N is presented on valid_out/data_out in cycle N+1 when the buffer was empty.
- Throughput: 1 flit/cycle sustained when ready_out is held high.
- Ordering: strict FIFO. No flit is duplicated or reordered.
- Consumer-side rule: while valid_out = 1 and ready_out = 0, data_out holds stable.
- yummy_in is a register, set to pop each cycle:
  - Exactly one 1-cycle pulse in cycle N+1 for each pop in cycle N.
  - Back-to-back pops give consecutive high cycles.
  - Total yummy pulses always equal total pops.
- Overflow:
  - valid_in while count == DEPTH and no pop: the flit is dropped and no pointer or count changes.
  - overflow_err is set and stays at 1 until reset.
  - No yummy is generated for a dropped flit.
- Empty: a pop cannot occur because valid_out = 0. Pointer wrap-around is transparent; the full/empty decision uses count only.
- occupancy = count, registered.
- Reset mid-operation:
  - All buffered flits are discarded and no yummy pulses are issued for them.
  - A yummy pulse pending at assertion is suppressed.
  - The sender must also be reset to restore DEPTH credits.

Test Plan:
- Single flit: reset, push 0xA5 at cycle 0, ready_out = 1 -> valid_out = 1 with data_out = 0xA5 at cycle 1; yummy_in pulses at cycle 2; occupancy goes 0 -> 1 -> 0.
- Fill with stall: ready_out = 0, push 16 flits 0..15 -> occupancy = 16, no yummy. Then ready_out = 1 -> 0..15 appear in order on 16 consecutive cycles, 16 consecutive yummy cycles, then valid_out = 0.
- Overflow and full-with-pop:
  - Buffer full, ready_out = 0, push 0xFF -> flit dropped, overflow_err = 1, occupancy stays 16.
  - Next cycle ready_out = 1 with valid_in = 1 -> push accepted, occupancy stays 16.
- Wrap-around streaming: 40 flits with random valid_in and random ready_out -> output sequence equals input sequence, yummy count equals pop count, occupancy never exceeds 16.
- Consumer backpressure: hold ready_out low for 5 cycles while valid_out = 1 -> data_out stable, no yummy pulses.
- Async reset: assert reset mid-stream with occupancy 7 -> valid_out, yummy_in and occupancy are 0 immediately, without a clock edge. After release, a new flit 0x3C is output first.
